// File: rtl/writeback_arbiter.sv
// Two-source register-file write-port arbiter: ALU results have fixed priority,
// and load results are guaranteed a win after MAX_WAIT consecutive losses.
module writeback_arbiter #(
  parameter int REG_COUNT = 32,
  parameter int REG_WIDTH = 32,
  parameter int MAX_WAIT  = 4,
  parameter int DROP_ZERO = 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         alu_valid_i,
  output logic                         alu_ready_o,
  input  logic [$clog2(REG_COUNT)-1:0] alu_rd_i,
  input  logic [REG_WIDTH-1:0]         alu_data_i,
  input  logic                         mem_valid_i,
  output logic                         mem_ready_o,
  input  logic [$clog2(REG_COUNT)-1:0] mem_rd_i,
  input  logic [REG_WIDTH-1:0]         mem_data_i,
  output logic                         wr_en_o,
  output logic [$clog2(REG_COUNT)-1:0] wr_address_o,
  output logic [REG_WIDTH-1:0]         wr_data_o,
  output logic                         idle_o
);

  localparam int AW = $clog2(REG_COUNT);
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic                 alu_hold_valid;
  logic [AW-1:0]        alu_hold_rd;
  logic [REG_WIDTH-1:0] alu_hold_data;
  logic                 mem_hold_valid;
  logic [AW-1:0]        mem_hold_rd;
  logic [REG_WIDTH-1:0] mem_hold_data;
  logic [7:0]           wait_cnt;

  logic alu_grant;
  logic mem_grant;
  logic alu_xfer;
  logic mem_xfer;
  logic alu_load;
  logic mem_load;
  logic both_valid;

  // Grants look only at holder state, so ready never depends on valid.
  always_comb begin
    both_valid = alu_hold_valid && mem_hold_valid;
    alu_grant  = alu_hold_valid && (!mem_hold_valid || (wait_cnt < WAIT_LIMIT));
    mem_grant  = mem_hold_valid && (!alu_hold_valid || (wait_cnt >= WAIT_LIMIT));
  end

  assign alu_ready_o = !alu_hold_valid || alu_grant;
  assign mem_ready_o = !mem_hold_valid || mem_grant;

  assign alu_xfer = alu_valid_i && alu_ready_o;
  assign mem_xfer = mem_valid_i && mem_ready_o;

  // Writes to r0 complete the handshake but never occupy a holder.
  assign alu_load = alu_xfer && !((DROP_ZERO != 0) && (alu_rd_i == '0));
  assign mem_load = mem_xfer && !((DROP_ZERO != 0) && (mem_rd_i == '0));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      alu_hold_valid <= 1'b0;
      alu_hold_rd    <= '0;
      alu_hold_data  <= '0;
    end else if (alu_load) begin
      alu_hold_valid <= 1'b1;
      alu_hold_rd    <= alu_rd_i;
      alu_hold_data  <= alu_data_i;
    end else if (alu_grant) begin
      alu_hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_hold_valid <= 1'b0;
      mem_hold_rd    <= '0;
      mem_hold_data  <= '0;
    end else if (mem_load) begin
      mem_hold_valid <= 1'b1;
      mem_hold_rd    <= mem_rd_i;
      mem_hold_data  <= mem_data_i;
    end else if (mem_grant) begin
      mem_hold_valid <= 1'b0;
    end
  end

  // Counts contested cycles the load path has lost in a row.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wait_cnt <= '0;
    end else if (mem_grant || !mem_hold_valid) begin
      wait_cnt <= '0;
    end else if (both_valid) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_en_o      <= 1'b0;
      wr_address_o <= '0;
      wr_data_o    <= '0;
    end else begin
      wr_en_o <= alu_grant || mem_grant;
      if (alu_grant) begin
        wr_address_o <= alu_hold_rd;
        wr_data_o    <= alu_hold_data;
      end else if (mem_grant) begin
        wr_address_o <= mem_hold_rd;
        wr_data_o    <= mem_hold_data;
      end
    end
  end

  assign idle_o = !alu_hold_valid && !mem_hold_valid && !wr_en_o;

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Single-write-port arbiter sitting directly upstream of the processor register file.
- Merges results from two producers onto the file's one write port (address/data/enable): the ALU path and the load-memory path.
- Each source has a valid/ready channel and a one-entry holding register.
- Fixed ALU priority with an anti-starvation counter for the memory path; registered write outputs.

Parameters:
- REG_COUNT, 32, number of architectural registers; address width is $clog2(REG_COUNT).
- REG_WIDTH, 32, data width of a register.
- MAX_WAIT, 4, consecutive lost arbitrations after which the memory path wins; legal range 1..255.
- DROP_ZERO, 1, when 1, writes targeting register 0 are accepted and discarded.

Ports:
- clk_i  in  1  clock, rising-edge.
- reset_i  in  1  asynchronous, active-high reset.
- alu_valid_i  in  1  ALU result valid.
- alu_ready_o  out  1  ALU channel can accept.
- alu_rd_i  in  $clog2(REG_COUNT)  ALU destination register.
- alu_data_i  in  REG_WIDTH  ALU result.
- mem_valid_i  in  1  load result valid.
- mem_ready_o  out  1  load channel can accept.
- mem_rd_i  in  $clog2(REG_COUNT)  load destination register.
- mem_data_i  in  REG_WIDTH  load result.
- wr_en_o  out  1  register-file write enable.
- wr_address_o  out  $clog2(REG_COUNT)  register-file write address.
- wr_data_o  out  REG_WIDTH  register-file write data.
- idle_o  out  1  both holding registers and output stage empty.

Behaviour:
- Reset: one clock, clk_i; reset_i is asynchronous and active-high. While asserted, both holding registers are invalid, wait_cnt=0, wr_en_o=0, wr_address_o=0, wr_data_o=0, idle_o=1. alu_ready_o and mem_ready_o read 1 (empty holders). Reset mid-operation discards held and in-flight writes.
- Handshake: transfer occurs on a rising edge when valid_i && ready_o.
  - x_ready_o = !x_hold_valid || x_grant.
  - ready depends only on holding state, never on valid_i, so there is no combinational loop.
  - valid_i/rd/data must stay stable until the transfer.
- Zero drop: with DROP_ZERO=1, a transfer whose rd==0 completes normally but does not load the holder. It never produces wr_en_o. With DROP_ZERO=0 it is handled like any other write.
- Arbitration is combinational on holding-register state only:
  - Only one holder valid: that holder is granted.
  - Both valid and wait_cnt<MAX_WAIT: ALU granted, wait_cnt increments.
  - Both valid and wait_cnt==MAX_WAIT: memory granted.
  - wait_cnt clears on any memory grant and whenever the memory holder is empty. It never exceeds MAX_WAIT.
- Output stage: on each edge, wr_en_o <= any_grant. If granted, wr_address_o and wr_data_o load from the granted holder; otherwise they hold their previous value.
  - The granted holder is freed on the same edge, or reloaded if its channel transfers on that edge (back-to-back, full throughput per source).
- Latency: an input accepted at edge k with its holder uncontested drives wr_en_o high for the cycle after edge k+1. The register file captures mid-cycle on the falling edge.
- Throughput: one write per cycle total. A source loses at most MAX_WAIT consecutive cycles while the other has a continuous stream.
- Ordering: upstream guarantees that the two channels never hold outstanding writes to the same rd simultaneously. The arbiter does no rd-hazard reordering.
- idle_o = !alu_hold_valid && !mem_hold_valid && !wr_en_o.

Test Plan:
- Reset, then a single ALU transfer rd=5 data=0xDEADBEEF at edge 1 -> wr_en_o=1, wr_address_o=5, wr_data_o=0xDEADBEEF after edge 2 for exactly one cycle. idle_o returns to 1.
- ALU and memory transfer in the same edge (rd=3/0x11, rd=7/0x22) -> ALU write at cycle+2, memory write at cycle+3. mem_ready_o is 0 for one cycle.
- ALU valid continuously and memory valid with MAX_WAIT=4 -> memory granted on the 5th contested cycle, then ALU resumes. Memory never waits more than 4 cycles over 100 cycles of stress.
- ALU rd=0 data=0x55 with DROP_ZERO=1 -> handshake completes and wr_en_o stays 0. The same stimulus with DROP_ZERO=0 produces a write to address 0.
- Back-to-back ALU stream of 8 values, memory idle -> 8 consecutive wr_en_o cycles in order, alu_ready_o held at 1 throughout.
- Assert reset_i asynchronously (between edges) while both holders are valid -> wr_en_o drops immediately. No held write appears after reset release, and the ready outputs read 1.
